// File: rtl/mem_pkg.sv
// Shared types and default sizes for the data-memory store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_DEPTH      = 4;

    // One buffered store. The valid bit is held apart from adrs/data in the
    // storage so that only it needs a reset.
    typedef struct packed {
        logic                     valid;
        logic [SB_DATA_WIDTH-1:0] adrs;
        logic [SB_DATA_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first address match of a load against the occupied buffer entries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only observes buffer state.
module sb_fwd_match
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  sb_entry_t             ent_i [DEPTH],
    input  logic [PTR_W-1:0]      head_i,
    input  logic [PTR_W:0]        count_i,
    input  logic [DATA_WIDTH-1:0] ld_adrs_i,
    output logic                  hit_o,
    output logic [PTR_W-1:0]      sel_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (head) to youngest; later matches overwrite earlier
    // ones, so the surviving selection is the entry nearest tail-1.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_i) && ent_i[idx].valid &&
                (ent_i[idx].adrs == ld_adrs_i)) begin
                hit_o = 1'b1;
                sel_o = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of dMem: queues stores, drains one per idle port cycle, forwards youngest match to loads.
// Latency: a store reaches dMem no earlier than the edge after it is accepted; load forwarding is combinational.
// Backpressure: st_ready drops when all DEPTH entries are occupied; loads always win the memory port.
module store_buffer
    import mem_pkg::*;
#(
    // DATA_WIDTH must track mem_pkg::SB_DATA_WIDTH, since entries use sb_entry_t.
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int DEPTH      = SB_DEPTH,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  st_valid,
    input  logic [DATA_WIDTH-1:0] st_adrs,
    input  logic [DATA_WIDTH-1:0] st_wd,
    output logic                  st_ready,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_adrs,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_hit,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_adrs,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  sb_empty,
    output logic [PTR_W:0]        sb_count
);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W:0]        count_q, count_d;

    logic                  ent_vld_q  [DEPTH];
    logic [DATA_WIDTH-1:0] ent_adrs_q [DEPTH];
    logic [DATA_WIDTH-1:0] ent_dat_q  [DEPTH];
    sb_entry_t             ent        [DEPTH];

    logic                  push;
    logic                  pop;
    logic                  fwd_hit;
    logic [PTR_W-1:0]      fwd_sel;

    // Ready is a pure function of registered occupancy; a pop in a full
    // cycle does not reopen the buffer until the following cycle.
    assign st_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;

    // Loads own the port; a store only drains in a load-free cycle.
    assign push = st_valid && st_ready;
    assign pop  = !ld_valid && (count_q != '0);

    // Next-state for the FIFO pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // Pointer and occupancy registers; reset discards any pending stores.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry valid bits: cleared on pop, set on push.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_vld_q[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                ent_vld_q[head_q] <= 1'b0;
            end
            if (push) begin
                ent_vld_q[tail_q] <= 1'b1;
            end
        end
    end

    // Entry payload storage; left unreset since valid bits qualify it.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_adrs_q[tail_q] <= st_adrs;
            ent_dat_q[tail_q]  <= st_wd;
        end
    end

    // Present the storage as entry structs for the matcher.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent[i].valid = ent_vld_q[i];
            ent[i].adrs  = ent_adrs_q[i];
            ent[i].data  = ent_dat_q[i];
        end
    end

    sb_fwd_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_fwd_match (
        .ent_i      (ent),
        .head_i     (head_q),
        .count_i    (count_q),
        .ld_adrs_i  (ld_adrs),
        .hit_o      (fwd_hit),
        .sel_o      (fwd_sel)
    );

    // Load result: forwarded data only for a valid load that matched, so a
    // store arriving this same cycle is never visible to the load.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = mem_rdata;
        if (ld_valid && fwd_hit) begin
            ld_hit  = 1'b1;
            ld_data = ent_dat_q[fwd_sel];
        end
    end

    // Memory port arbitration: load read, else drain head, else idle.
    always_comb begin
        mem_we   = 1'b0;
        mem_adrs = '0;
        mem_wd   = '0;
        if (ld_valid) begin
            mem_adrs = ld_adrs;
        end else if (count_q != '0) begin
            mem_we   = 1'b1;
            mem_adrs = ent_adrs_q[head_q];
            mem_wd   = ent_dat_q[head_q];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomised and directed scoreboard bench for store_buffer against a queue-based model.
// Latency: expectations are recorded per cycle and checked at the following falling edge.
// Backpressure: the model ignores stores presented while it holds DEPTH entries.
module tb_store_buffer;
    import mem_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          st_valid = 1'b0;
    logic [DW-1:0] st_adrs = '0;
    logic [DW-1:0] st_wd = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_adrs = '0;
    logic [DW-1:0] ld_data;
    logic          ld_hit;
    logic          mem_we;
    logic [DW-1:0] mem_adrs;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rdata;
    logic          sb_empty;
    logic [PW:0]   sb_count;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .st_valid  (st_valid),
        .st_adrs   (st_adrs),
        .st_wd     (st_wd),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_adrs   (ld_adrs),
        .ld_data   (ld_data),
        .ld_hit    (ld_hit),
        .mem_we    (mem_we),
        .mem_adrs  (mem_adrs),
        .mem_wd    (mem_wd),
        .mem_rdata (mem_rdata),
        .sb_empty  (sb_empty),
        .sb_count  (sb_count)
    );

    // dMem stand-in driven by the DUT, and the bench's own expected image.
    logic [DW-1:0] dmem   [256];
    logic [DW-1:0] refmem [256];

    assign mem_rdata = dmem[mem_adrs[7:0]];

    always @(posedge CLK) begin
        if (mem_we) dmem[mem_adrs[7:0]] <= mem_wd;
    end

    typedef struct {
        logic          st_ready;
        logic          empty;
        logic [PW:0]   count;
        logic          we;
        logic [DW-1:0] adrs;
        logic [DW-1:0] wd;
        logic          hit;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    exp_t exp_q [$];
    st_t  mq    [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; expectations derive from the in-order queue model.
    task automatic cyc(input logic sv, input logic [DW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lv, input logic [DW-1:0] la);
        exp_t e;
        st_t  s;
        logic do_push;
        @(posedge CLK);
        #1;
        RST_N    = 1'b1;
        st_valid = sv;
        st_adrs  = sa;
        st_wd    = sd;
        ld_valid = lv;
        ld_adrs  = la;
        e.st_ready = (mq.size() != DEPTH);
        e.empty    = (mq.size() == 0);
        e.count    = (PW+1)'(mq.size());
        e.hit      = 1'b0;
        e.data     = '0;
        if (lv) begin
            e.we   = 1'b0;
            e.adrs = la;
            e.wd   = '0;
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (mq[k].a == la) begin
                    e.hit  = 1'b1;
                    e.data = mq[k].d;
                    break;
                end
            end
        end else if (mq.size() > 0) begin
            e.we   = 1'b1;
            e.adrs = mq[0].a;
            e.wd   = mq[0].d;
        end else begin
            e.we   = 1'b0;
            e.adrs = '0;
            e.wd   = '0;
        end
        if (!e.hit) e.data = refmem[e.adrs[7:0]];
        exp_q.push_back(e);
        do_push = sv && (mq.size() != DEPTH);
        if (e.we) begin
            refmem[e.adrs[7:0]] = e.wd;
            s = mq.pop_front();
        end
        if (do_push) begin
            s.a = sa;
            s.d = sd;
            mq.push_back(s);
        end
    endtask

    task automatic rst(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(posedge CLK);
            #1;
            RST_N    = 1'b0;
            st_valid = 1'b0;
            ld_valid = 1'b0;
            mq.delete();
            e.st_ready = 1'b1;
            e.empty    = 1'b1;
            e.count    = '0;
            e.we       = 1'b0;
            e.adrs     = '0;
            e.wd       = '0;
            e.hit      = 1'b0;
            e.data     = refmem[0];
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("st_ready", DW'(st_ready), DW'(e.st_ready));
                chk("sb_empty", DW'(sb_empty), DW'(e.empty));
                chk("sb_count", DW'(sb_count), DW'(e.count));
                chk("mem_we",   DW'(mem_we),   DW'(e.we));
                chk("mem_adrs", mem_adrs,      e.adrs);
                chk("mem_wd",   mem_wd,        e.wd);
                chk("ld_hit",   DW'(ld_hit),   DW'(e.hit));
                chk("ld_data",  ld_data,       e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]   = 32'h1000_0000 + i;
            refmem[i] = 32'h1000_0000 + i;
        end
        dmem[8'h30]   = 32'h0000_CAFE;
        refmem[8'h30] = 32'h0000_CAFE;

        // Reset then idle.
        rst(2);
        idle(5);

        // Single store drains on the next load-free cycle.
        cyc(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0);
        idle(2);

        // Fill under continuous loads; fifth store is ignored, then drain.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(i), 32'hA000_0000 + DW'(i), 1'b1, 32'h80);
        idle(5);

        // Youngest-match forwarding.
        cyc(1'b1, 32'h20, 32'h1111, 1'b1, 32'h80);
        cyc(1'b1, 32'h20, 32'h2222, 1'b1, 32'h80);
        cyc(1'b0, '0, '0, 1'b1, 32'h20);
        idle(3);

        // Miss path reads dMem, no pop.
        cyc(1'b1, 32'h20, 32'h5555, 1'b1, 32'h80);
        cyc(1'b0, '0, '0, 1'b1, 32'h30);
        idle(2);

        // Same-cycle store and load to 0x40: load sees the old memory value.
        cyc(1'b1, 32'h40, 32'h0000_ABCD, 1'b1, 32'h40);
        cyc(1'b0, '0, '0, 1'b1, 32'h40);
        idle(2);

        // Reset with three pending stores discards them.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h50 + DW'(i), 32'hB000_0000 + DW'(i), 1'b1, 32'h80);
        rst(1);
        idle(4);

        // Randomised traffic over a small address set to provoke hits.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), DW'(4 * $urandom_range(0, 7)), DW'($urandom),
                ($urandom_range(0, 2) == 0), DW'(4 * $urandom_range(0, 7)));
        end
        idle(6);

        repeat (2) @(posedge CLK);
        chk("scoreboard_drained", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly upstream of the data memory (dMem) in the pipelined datapath.
- The MEM stage hands stores to this block and continues without waiting. The buffer drains queued stores into dMem one per cycle whenever the single memory port is idle.
- Loads own the memory port. Any load that hits a buffered store gets the youngest matching store data forwarded, so program order is preserved.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- DEPTH, 4, number of buffer entries (power of two, ≥2).
- PTR_W, $clog2(DEPTH), head/tail pointer width.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- st_valid  input  1  MEM stage presents a store this cycle.
- st_adrs  input  DATA_WIDTH  store word address.
- st_wd  input  DATA_WIDTH  store data.
- st_ready  output  1  buffer can accept a store (not full).
- ld_valid  input  1  MEM stage presents a load this cycle.
- ld_adrs  input  DATA_WIDTH  load word address.
- ld_data  output  DATA_WIDTH  load result: forwarded entry data on hit, else mem_rdata.
- ld_hit  output  1  load was satisfied from the buffer.
- mem_we  output  1  write enable to dMem.
- mem_adrs  output  DATA_WIDTH  dMem address.
- mem_wd  output  DATA_WIDTH  dMem write data.
- mem_rdata  input  DATA_WIDTH  dMem asynchronous read data.
- sb_empty  output  1  no pending stores (used for fences and halt).
- sb_count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Reset (RST_N low, asynchronous): head=0, tail=0, count=0, all entry valid bits cleared.
  - Outputs during and after reset: st_ready=1, sb_empty=1, sb_count=0, mem_we=0, ld_hit=0.
  - Entry data and address storage are not reset.
  - Reset asserted mid-drain discards all pending stores. This is required behaviour, not an error.
- Storage: circular FIFO of {adrs, data}. Push at tail, pop at head. Pointers wrap modulo DEPTH.
- st_ready = (count != DEPTH). It is purely registered-state derived, with no combinational path from any input.
- Push occurs on a rising edge when st_valid && st_ready. A store presented while full is ignored; upstream must stall.
- Port arbitration is combinational from registered state and the current ld_valid:
  - ld_valid=1: mem_we=0, mem_adrs=ld_adrs, mem_wd=0. No pop this cycle.
  - ld_valid=0 and count>0: mem_we=1, mem_adrs=head.adrs, mem_wd=head.data. Pop on the same rising edge, so the dMem write and the pop coincide.
  - Otherwise: mem_we=0, mem_adrs=0, mem_wd=0.
- Forwarding (combinational, zero latency):
  - Compare ld_adrs against all valid entries and select the youngest match (the entry nearest tail-1, scanning backwards).
  - Match: ld_hit=1, ld_data=that entry's data.
  - No match: ld_hit=0, ld_data=mem_rdata.
  - With ld_valid=0, ld_hit=0 and ld_data=mem_rdata.
- Simultaneous st_valid and ld_valid:
  - The store is pushed (if not full). The load does NOT see the store arriving in that cycle; it sees buffer state before the push.
  - No pop occurs that cycle.
- Simultaneous push and pop (st_valid, ld_valid=0, 0<count<DEPTH): count unchanged, both pointers advance.
- When full, the pop in the same cycle does not enable a push. st_ready stays 0 for that cycle and goes to 1 the next cycle.
- Drain latency: a store accepted at edge N is written to dMem no earlier than edge N+1 and at the first load-free cycle after all older entries have drained.
- Starvation: continuous loads block draining indefinitely. This is acceptable because the pipeline issues at most one memory op per cycle.
- sb_empty = (count==0). sb_count = count.
- Address comparison is exact over the full DATA_WIDTH; no sub-word masking.

Decomposition:
- Shared package `mem_pkg`:
  - DATA_WIDTH and DEPTH defaults.
  - Struct `sb_entry_t` {valid, adrs, data}.
  - Function `clog2` helper if the toolchain lacks $clog2.
- One sub-module: `sb_fwd_match`. It is purely combinational. It takes the entry array, head, count and ld_adrs, and produces hit plus the selected index using youngest-first priority.
- The FIFO control and arbitration stay in store_buffer.

Test Plan:
- Reset then idle: RST_N low 2 cycles, release → st_ready=1, sb_empty=1, sb_count=0, mem_we=0 for 5 idle cycles.
- Single store drain: store adrs=0x10, wd=0xDEADBEEF with ld_valid=0 → next cycle mem_we=1, mem_adrs=0x10, mem_wd=0xDEADBEEF; following cycle sb_empty=1.
- Fill and stall: 4 back-to-back stores (adrs 0..3) with ld_valid held 1 → st_ready=0 after the 4th, 5th store ignored. Drop ld_valid → entries drain in order 0,1,2,3, one per cycle.
- Youngest-forward: stores (0x20, 0x1111) then (0x20, 0x2222), load 0x20 while both are buffered → ld_hit=1, ld_data=0x2222, mem_we=0 that cycle.
- Miss path: dMem preloaded with 0xCAFE at 0x30, buffer holds 0x20 only, load 0x30 → ld_hit=0, ld_data=0xCAFE, no pop.
- Same-cycle store+load to 0x40 with an empty buffer → ld_hit=0, ld_data=mem_rdata (old value). Next-cycle load 0x40 → ld_hit=1 with the new data.
- Reset mid-operation: 3 entries queued, RST_N pulsed low → sb_count=0 and no further mem_we.
